// File: rtl/alu_issue.sv
`timescale 1ns/1ps
// alu_issue: execute-stage issue controller between decode and the ALU.
// Holds one decoded instruction in a slot for the FP unit's fixed latency,
// retires it with an n_stall pulse, tracks the write-back destination and
// discards an instruction accepted alongside a taken branch.
//
// Optional feature: define ALU_ISSUE_FWD_EN to forward the retiring ALU result
// (alu_fwd) and the registered write-back result (wb_res) into the operands
// of the instruction being accepted. Without it, operands always come from
// decode and a dependent instruction is held off by an id_ready interlock
// until the register file holds the value.
//
// Handshake (id_valid/id_ready): an instruction transfers on a rising edge
// where both are high; id_ready never depends on id_valid, and decode keeps
// all id_* fields stable while id_valid is high and id_ready is low.
//
// The FSM state is held in state_q (S_EMPTY / S_BUSY) for checkers to bind to.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [6:0]  id_aluctl,
  input  logic [6:0]  id_branch,
  input  logic [31:0] id_op1,
  input  logic [31:0] id_op2,
  input  logic [5:0]  id_rs1,
  input  logic [5:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [5:0]  id_rd,
  input  logic        id_we,
  input  logic        ex_hold,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [6:0]  aluctl,
  output logic [6:0]  dec_branch,
  output logic        n_stall,
  input  logic [31:0] alu_fwd,
  input  logic [31:0] wb_res,
  input  logic        flush,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [5:0]  wb_rd
);

  // aluctl shown while the slot is empty: an encoding the ALU never executes.
  localparam logic [6:0] CTL_IDLE = 7'b0111011;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_BUSY  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] slot_op1, slot_op2;
  logic [6:0]  slot_ctl, slot_br;
  logic [5:0]  slot_rd;
  logic        slot_we;

  logic        busy;
  logic        retire;
  logic        accept;
  logic        load;
  logic        hazard;
  logic [31:0] src_op1, src_op2;

  // FP unit latency in cycles, decoded from the low six aluctl bits.
  function automatic logic [1:0] lat_of(input logic [5:0] c);
    logic [1:0] l;
    case (c)
      6'b010011:                                  l = 2'd3; // fdiv
      6'b010000, 6'b010001, 6'b010010, 6'b010100: l = 2'd2; // fadd fsub fmul fsqrt
      6'b010110, 6'b010111, 6'b011001, 6'b011010: l = 2'd1; // fmin fmax flt fle
      default:                                    l = 2'd0;
    endcase
    return l;
  endfunction

  assign busy   = (state_q == S_BUSY);
  assign retire = busy && (cnt_q == 2'd0) && !ex_hold;
  assign accept = id_valid && id_ready;

`ifdef ALU_ISSUE_FWD_EN
  // Operand source: retiring result first, then the write-back result, else decode.
  function automatic logic [31:0] fwd_pick(
    input logic [5:0]  rs,
    input logic        use_rs,
    input logic [31:0] reg_val,
    input logic        alu_en,
    input logic [5:0]  alu_rd,
    input logic [31:0] alu_val,
    input logic        wbk_en,
    input logic [5:0]  wbk_rd,
    input logic [31:0] wbk_val
  );
    logic [31:0] v;
    v = reg_val;
    if (use_rs && (rs != 6'd0)) begin
      if (alu_en && (rs == alu_rd))
        v = alu_val;
      else if (wbk_en && (rs == wbk_rd))
        v = wbk_val;
    end
    return v;
  endfunction

  assign src_op1 = fwd_pick(id_rs1, id_use_rs1, id_op1, retire && slot_we, slot_rd, alu_fwd,
                            wb_valid && wb_we, wb_rd, wb_res);
  assign src_op2 = fwd_pick(id_rs2, id_use_rs2, id_op2, retire && slot_we, slot_rd, alu_fwd,
                            wb_valid && wb_we, wb_rd, wb_res);
  assign hazard  = 1'b0;
`else
  // A used source register is still in flight in the slot or in write-back.
  function automatic logic src_hit(
    input logic [5:0] rs,
    input logic       use_rs,
    input logic       slot_en,
    input logic [5:0] s_rd,
    input logic       wbk_en,
    input logic [5:0] wbk_rd
  );
    return use_rs && (rs != 6'd0) &&
           ((slot_en && (rs == s_rd)) || (wbk_en && (rs == wbk_rd)));
  endfunction

  logic unused_fwd;

  assign src_op1    = id_op1;
  assign src_op2    = id_op2;
  assign hazard     = src_hit(id_rs1, id_use_rs1, busy && slot_we, slot_rd, wb_valid && wb_we, wb_rd) ||
                      src_hit(id_rs2, id_use_rs2, busy && slot_we, slot_rd, wb_valid && wb_we, wb_rd);
  assign unused_fwd = ^{alu_fwd, wb_res};
`endif

  assign id_ready = (!busy || retire) && !hazard;
  assign n_stall  = retire;

  // Next state: load on accept, count down the latency, drop the slot on retire.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_BUSY;
          load    = 1'b1;
        end
      end
      S_BUSY: begin
        if (retire) begin
          // An instruction accepted with a taken branch is wrong-path: drop it.
          if (accept && !flush)
            load = 1'b1;
          else
            state_d = S_EMPTY;
        end else if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (load)
      cnt_d = lat_of(id_aluctl[5:0]);
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slot payload, captured once per accepted instruction and held while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_op1 <= 32'd0;
      slot_op2 <= 32'd0;
      slot_ctl <= 7'd0;
      slot_br  <= 7'd0;
      slot_rd  <= 6'd0;
      slot_we  <= 1'b0;
    end else if (load) begin
      slot_op1 <= src_op1;
      slot_op2 <= src_op2;
      slot_ctl <= id_aluctl;
      slot_br  <= id_branch;
      slot_rd  <= id_rd;
      slot_we  <= id_we;
    end
  end

  // Write-back tracking: one cycle of wb_valid after each retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= 6'd0;
    end else begin
      wb_valid <= retire;
      if (retire) begin
        wb_rd <= slot_rd;
        wb_we <= slot_we;
      end
    end
  end

  // ALU-facing outputs: slot contents while busy, an inert instruction when empty.
  always_comb begin
    op1        = 32'd0;
    op2        = 32'd0;
    aluctl     = CTL_IDLE;
    dec_branch = 7'd0;
    if (busy) begin
      op1        = slot_op1;
      op2        = slot_op2;
      aluctl     = slot_ctl;
      dec_branch = slot_br;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
`timescale 1ns/1ps
// tb_alu_issue: directed scenarios plus randomized traffic for alu_issue,
// checked every cycle against a transaction-level model of the issue slot.
module tb_alu_issue;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [6:0]  id_aluctl, id_branch;
  logic [31:0] id_op1, id_op2;
  logic [5:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_we;
  logic        ex_hold;
  logic [31:0] op1, op2;
  logic [6:0]  aluctl, dec_branch;
  logic        n_stall;
  logic [31:0] alu_fwd;
  logic [31:0] wb_res = 32'd0;
  logic        flush;
  logic        wb_valid, wb_we;
  logic [5:0]  wb_rd;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_aluctl(id_aluctl), .id_branch(id_branch),
    .id_op1(id_op1), .id_op2(id_op2),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we),
    .ex_hold(ex_hold),
    .op1(op1), .op2(op2), .aluctl(aluctl), .dec_branch(dec_branch),
    .n_stall(n_stall),
    .alu_fwd(alu_fwd), .wb_res(wb_res), .flush(flush),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd)
  );

  // ---------------- ALU stand-in ----------------
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [6:0] c);
    case (c[5:0])
      6'h13:   return (a == 32'h40C00000 && b == 32'h40000000) ? 32'h40400000 : (a ^ b);
      6'h01:   return a - b;
      default: return a + b;
    endcase
  endfunction

  function automatic bit br_taken(input logic [6:0] br, input logic [31:0] a, input logic [31:0] b);
    return br[6] && ((br[0] && a == b) || (br[1] && a != b) ||
                     (br[2] && $signed(a) <  $signed(b)) || (br[3] && $signed(a) >= $signed(b)) ||
                     (br[4] && a <  b) || (br[5] && a >= b));
  endfunction

  assign alu_fwd = alu_f(op1, op2, aluctl);
  assign flush   = n_stall && br_taken(dec_branch, op1, op2);
  always @(posedge clk) if (n_stall) wb_res <= alu_fwd;

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  ctl;
    logic [6:0]  br;
    logic [5:0]  rd;
    logic        we;
  } inst_t;

  inst_t       m_cur;
  bit          m_busy  = 0;
  int          m_acc   = 0;   // first cycle the instruction sits in the slot
  bit          m_wbv   = 0;
  logic [5:0]  m_wbrd  = 6'd0;
  logic        m_wbwe  = 1'b0;
  logic [31:0] m_wbres = 32'd0;
  int          cyc     = 0;

  function automatic int lat_of(input logic [6:0] c);
    case (c[5:0])
      6'b010011:                                  return 3;
      6'b010000, 6'b010001, 6'b010010, 6'b010100: return 2;
      6'b010110, 6'b010111, 6'b011001, 6'b011010: return 1;
      default:                                    return 0;
    endcase
  endfunction

  function automatic bit m_hz(input logic [5:0] rs, input logic u);
`ifdef ALU_ISSUE_FWD_EN
    return 1'b0;
`else
    return u && rs != 6'd0 &&
           ((m_busy && m_cur.we && rs == m_cur.rd) || (m_wbv && m_wbwe && rs == m_wbrd));
`endif
  endfunction

  function automatic logic [31:0] m_src(input logic [5:0] rs, input logic u, input logic [31:0] regv,
                                        input bit ret, input logic [31:0] res);
`ifdef ALU_ISSUE_FWD_EN
    if (u && rs != 6'd0) begin
      if (ret && m_cur.we && rs == m_cur.rd) return res;
      if (m_wbv && m_wbwe && rs == m_wbrd) return m_wbres;
    end
`endif
    return regv;
  endfunction

  // One cycle of the model: compare outputs, then advance on the coming edge.
  task automatic model_step();
    bit          retire, exp_ready, accept, taken;
    logic [31:0] res;
    inst_t       nx;
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_wbv = 0; m_wbrd = 6'd0; m_wbwe = 1'b0;
      chk("rst_n_stall",  32'(n_stall),  32'd0);
      chk("rst_id_ready", 32'(id_ready), 32'd1);
      chk("rst_aluctl",   32'(aluctl),   32'h3B);
      chk("rst_op1",      op1,           32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_rd",    32'(wb_rd),    32'd0);
      return;
    end
    retire    = m_busy && (cyc - m_acc >= lat_of(m_cur.ctl)) && !ex_hold;
    exp_ready = (!m_busy || retire) && !m_hz(id_rs1, id_use_rs1) && !m_hz(id_rs2, id_use_rs2);
    chk("n_stall",    32'(n_stall),    32'(retire));
    chk("id_ready",   32'(id_ready),   32'(exp_ready));
    chk("op1",        op1,             m_busy ? m_cur.a : 32'd0);
    chk("op2",        op2,             m_busy ? m_cur.b : 32'd0);
    chk("aluctl",     32'(aluctl),     m_busy ? 32'(m_cur.ctl) : 32'h3B);
    chk("dec_branch", 32'(dec_branch), m_busy ? 32'(m_cur.br) : 32'd0);
    chk("wb_valid",   32'(wb_valid),   32'(m_wbv));
    chk("wb_rd",      32'(wb_rd),      32'(m_wbrd));
    chk("wb_we",      32'(wb_we),      32'(m_wbwe));

    res    = alu_f(m_cur.a, m_cur.b, m_cur.ctl);
    taken  = retire && br_taken(m_cur.br, m_cur.a, m_cur.b);
    accept = id_valid && exp_ready;
    nx.a   = m_src(id_rs1, id_use_rs1, id_op1, retire, res);
    nx.b   = m_src(id_rs2, id_use_rs2, id_op2, retire, res);
    nx.ctl = id_aluctl; nx.br = id_branch; nx.rd = id_rd; nx.we = id_we;

    if (retire) begin
      m_wbv = 1; m_wbrd = m_cur.rd; m_wbwe = m_cur.we; m_wbres = res;
    end else begin
      m_wbv = 0;
    end
    if (accept && !taken) begin
      m_cur = nx; m_busy = 1; m_acc = cyc + 1;
    end else if (retire) begin
      m_busy = 0;
    end
  endtask

  always @(negedge clk) model_step();

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_aluctl = 7'd0; id_branch = 7'd0; id_op1 = 32'd0; id_op2 = 32'd0;
    id_rs1 = 6'd0; id_rs2 = 6'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd = 6'd0; id_we = 1'b0;
  endtask

  // Offer one instruction (called just after a rising edge); returns after the accepting edge.
  task automatic issue(input logic [6:0] ctl, input logic [6:0] br, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] rs1, input logic u1,
                       input logic [5:0] rs2, input logic u2, input logic [5:0] rd,
                       input logic we, output int waits);
    waits = 0;
    id_valid = 1'b1; id_aluctl = ctl; id_branch = br; id_op1 = a; id_op2 = b;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2; id_rd = rd; id_we = we;
    forever begin
      @(negedge clk);
      if (id_ready) break;
      waits++;
      if (waits > 40) begin
        chk("issue_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    sync();
    set_idle();
  endtask

  bit hold_rand = 0;
  initial forever begin
    @(posedge clk); #1;
    if (hold_rand) ex_hold = ($urandom_range(0, 3) == 0);
  end

  function automatic logic [5:0] rand_reg();
    int k = $urandom_range(0, 8);
    return (k < 6) ? 6'(k) : 6'(32 + k - 6);
  endfunction

  logic [6:0] ctl_tab [14] = '{7'h00, 7'h01, 7'h13, 7'h10, 7'h11, 7'h12, 7'h14,
                               7'h16, 7'h17, 7'h19, 7'h1a, 7'h53, 7'h15, 7'h18};

  // ---------------- stimulus ----------------
  initial begin
    int w, w2;
    rst_n = 1'b0; ex_hold = 1'b0; set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_id_ready",   32'(id_ready),   32'd1);
    chk("reset_aluctl",     32'(aluctl),     32'h3B);
    chk("reset_dec_branch", 32'(dec_branch), 32'd0);
    chk("reset_wb_we",      32'(wb_we),      32'd0);
    sync(); rst_n = 1'b1;
    sync();

    // add rd=5, 3+4: retires in the first slot cycle, write-back next.
    issue(7'h00, 7'd0, 32'd3, 32'd4, 6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1, w);
    @(negedge clk);
    chk("add_n_stall", 32'(n_stall), 32'd1);
    chk("add_op1",     op1,          32'd3);
    @(negedge clk);
    chk("add_wb_valid", 32'(wb_valid), 32'd1);
    chk("add_wb_rd",    32'(wb_rd),    32'd5);
    chk("add_wb_res",   wb_res,        32'd7);
    sync();

    // fdiv 6.0f / 2.0f: three held cycles, then retire.
    issue(7'h13, 7'd0, 32'h40C00000, 32'h40000000, 6'd0, 1'b0, 6'd0, 1'b0, 6'd33, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fdiv_n_stall_low", 32'(n_stall),  32'd0);
      chk("fdiv_ready_low",   32'(id_ready), 32'd0);
    end
    @(negedge clk);
    chk("fdiv_n_stall_high", 32'(n_stall), 32'd1);
    @(negedge clk);
    chk("fdiv_wb_res", wb_res, 32'h40400000);
    sync();

    // Dependent add pair on x5.
    issue(7'h00, 7'd0, 32'd3, 32'd4, 6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1, w);
`ifdef ALU_ISSUE_FWD_EN
    issue(7'h00, 7'd0, 32'd99, 32'd1, 6'd5, 1'b1, 6'd0, 1'b0, 6'd6, 1'b1, w2);
    @(negedge clk);
    chk("dep_waits", 32'(w2), 32'd0);
`else
    issue(7'h00, 7'd0, 32'd7, 32'd1, 6'd5, 1'b1, 6'd0, 1'b0, 6'd6, 1'b1, w2);
    @(negedge clk);
    chk("dep_waits", 32'(w2), 32'd2);
`endif
    chk("dep_op1", op1, 32'd7);
    sync();

    // beq 9==9 with a follower offered: follower is dropped.
    issue(7'h00, 7'b1000001, 32'd9, 32'd9, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, w);
    issue(7'h00, 7'd0, 32'd1, 32'd2, 6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1, w2);
    @(negedge clk);
    chk("flush_follower_waits", 32'(w2),     32'd0);
    chk("flush_aluctl",         32'(aluctl), 32'h3B);
    @(negedge clk);
    chk("flush_wb_valid", 32'(wb_valid), 32'd0);
    sync();

    // fmul under a four-cycle hold starting with the accept.
    ex_hold = 1'b1;
    issue(7'h12, 7'd0, 32'd5, 32'd6, 6'd0, 1'b0, 6'd0, 1'b0, 6'd34, 1'b1, w);
    chk("hold_empty_waits", 32'(w), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_n_stall_low", 32'(n_stall), 32'd0);
    end
    @(posedge clk); #1 ex_hold = 1'b0;
    @(negedge clk);
    chk("hold_n_stall_high", 32'(n_stall), 32'd1);
    @(negedge clk);
    chk("hold_n_stall_once", 32'(n_stall), 32'd0);
    sync();

    // Asynchronous reset while fdiv is two cycles from retiring.
    issue(7'h13, 7'd0, 32'd8, 32'd2, 6'd0, 1'b0, 6'd0, 1'b0, 6'd35, 1'b1, w);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_aluctl",   32'(aluctl),   32'h3B);
    chk("arst_op1",      op1,           32'd0);
    chk("arst_id_ready", 32'(id_ready), 32'd1);
    chk("arst_n_stall",  32'(n_stall),  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_no_wb", 32'(wb_valid), 32'd0);
    end
    sync();

    // Randomized traffic with hazards, holds, gaps and branches.
    hold_rand = 1;
    for (int n = 0; n < 1500; n++) begin
      logic [6:0]  ctl, br;
      logic [31:0] a, b;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) sync();
      ctl = ctl_tab[$urandom_range(0, 13)];
      br  = ($urandom_range(0, 7) == 0) ? {1'b1, 6'(1 << $urandom_range(0, 5))} : 7'd0;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(ctl, br, a, b, rand_reg(), 1'($urandom_range(0, 1)), rand_reg(),
            1'($urandom_range(0, 1)), rand_reg(), 1'($urandom_range(0, 1)), w);
    end
    hold_rand = 0;
    #1 ex_hold = 1'b0;
    repeat (10) sync();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
